// File: rtl/mips_mem_pkg.sv
// Shared types and sizing helpers for the main-memory arbiter.
// Holds the sequencer state, owner encoding and default block size.
package mips_mem_pkg;

    localparam int BLOCK_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic int beat_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure).
// A lone request wins outright; a tie goes to the side that did not own last.
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    output logic win_d
);

    always_comb begin
        win_d = 1'b0;
        if (req_i && req_d) begin
            win_d = (last_owner == OWN_D) ? 1'b0 : 1'b1;
        end else if (req_d) begin
            win_d = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache refill + write-back arbiter; one block burst per grant, gnt one cycle after req.
// mem_ready low stalls the burst with all memory outputs held; read beats return one cycle later.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             i_req,
    input  logic [ADDR_W-1:0]                i_addr,
    output logic                             i_gnt,
    output logic                             i_rvalid,
    output logic [DATA_W-1:0]                i_rdata,
    output logic [beat_w(BLOCK_WORDS)-1:0]   i_beat,
    output logic                             i_done,
    input  logic                             d_req,
    input  logic [ADDR_W-1:0]                d_addr,
    input  logic                             d_we,
    output logic                             d_gnt,
    output logic                             d_rvalid,
    output logic [DATA_W-1:0]                d_rdata,
    output logic [beat_w(BLOCK_WORDS)-1:0]   d_beat,
    output logic                             d_done,
    output logic [beat_w(BLOCK_WORDS)-1:0]   d_widx,
    input  logic [DATA_W-1:0]                d_wdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_ready
);

    localparam int BW  = beat_w(BLOCK_WORDS);
    localparam int OFF = BW + 2;

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d, last_q, last_d, winner;
    logic [ADDR_W-OFF-1:0]   base_q, base_d;
    logic                    we_q, we_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [BW-1:0]           i_beat_q, i_beat_d, d_beat_q, d_beat_d;
    logic                    win_d;
    logic [ADDR_W-1:0]       sel_addr;
    logic                    unused_addr_bits;

    rr_arb2 u_rr_arb2 (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_owner (last_q),
        .win_d      (win_d)
    );

    assign winner           = owner_e'(win_d);
    assign sel_addr         = (winner == OWN_D) ? d_addr : i_addr;
    assign unused_addr_bits = &{1'b0, sel_addr[OFF-1:0]};

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        base_d     = base_q;
        we_d       = we_q;
        beat_d     = beat_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_beat_d   = i_beat_q;
        d_beat_d   = d_beat_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = BURST;
                    owner_d = winner;
                    last_d  = winner;
                    base_d  = sel_addr[ADDR_W-1:OFF];
                    we_d    = (winner == OWN_D) && d_we;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (mem_ready) begin
                    beat_d = beat_q + 1'b1;
                    // Read beats are captured for the owner only; writes return nothing.
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rvalid_d = 1'b1;
                            d_rdata_d  = mem_rdata;
                            d_beat_d   = beat_q;
                        end else begin
                            i_rvalid_d = 1'b1;
                            i_rdata_d  = mem_rdata;
                            i_beat_d   = beat_q;
                        end
                    end
                    if (beat_q == BW'(BLOCK_WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            last_q     <= OWN_I;
            base_q     <= '0;
            we_q       <= 1'b0;
            beat_q     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_beat_q   <= '0;
            d_beat_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            base_q     <= base_d;
            we_q       <= we_d;
            beat_q     <= beat_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_beat_q   <= i_beat_d;
            d_beat_q   <= d_beat_d;
        end
    end

    assign mem_en    = (state_q == BURST);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? {base_q, beat_q, 2'b00} : '0;
    assign d_widx    = (mem_en && owner_q == OWN_D && we_q) ? beat_q : '0;
    assign mem_wdata = mem_we ? d_wdata : '0;

    assign i_gnt    = (state_q != IDLE) && (owner_q == OWN_I);
    assign d_gnt    = (state_q != IDLE) && (owner_q == OWN_D);
    assign i_done   = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done   = (state_q == DONE) && (owner_q == OWN_D);
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_beat   = i_beat_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_beat   = d_beat_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester main-memory arbiter and burst sequencer for the pipelined MIPS core. It shares the single main-memory port between instruction-cache refills (I side, read only) and data-cache refills and write-backs (D side, read or write). It sits between the caches and main memory inside the datapath, and it sequences one block-sized burst per grant. Per-beat progress is reported back to the owning cache.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- BLOCK_WORDS, 4, words per cache block; power of two, range 2..16.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  I-cache refill request; held until i_done.
- i_addr  in  ADDR_W  I-side block address; low offset bits are ignored.
- i_gnt  out  1  I side owns the memory port.
- i_rvalid  out  1  registered read beat is valid.
- i_rdata  out  DATA_W  registered read word.
- i_beat  out  log2(BLOCK_WORDS)  beat index of i_rdata.
- i_done  out  1  one-cycle pulse: I-side burst is complete.
- d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_beat, d_done: same meaning as the I-side ports, for the D side.
- d_we  in  1  D-side burst is a write-back; sampled at grant.
- d_widx  out  log2(BLOCK_WORDS)  index of the write word the D cache must present this cycle.
- d_wdata  in  DATA_W  write word, combinational response to d_widx.
- mem_en  out  1  memory beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned byte address of the beat.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid when mem_en and mem_ready are both high.
- mem_ready  in  1  memory accepts or completes the beat this cycle.

## Operation
- FSM has three states.
  - IDLE: no grant. If any request is pending, go to BURST with the winner latched.
  - BURST: mem_en=1. A beat completes on a cycle with mem_en & mem_ready. The beat counter increments on each completed beat. The completion of beat BLOCK_WORDS-1 moves the FSM to DONE.
  - DONE: the owner's done pulses for one cycle, then the FSM returns to IDLE.
- Arbitration is round-robin via last_owner, which resets to I.
  - Simultaneous requests go to the side that is not last_owner.
  - A single request is granted immediately.
- Latched at grant: owner, base address, and we (forced to 0 for I).
- mem_addr = {base[ADDR_W-1:OFF], beat, 2'b00}, where OFF = log2(BLOCK_WORDS)+2.
- mem_we = latched we. mem_wdata = d_wdata. d_widx = beat counter while the D side owns a write burst, 0 otherwise.
- mem_en, mem_addr, mem_we and mem_wdata are held stable until mem_ready.
- On each read-beat handshake, the owner's rdata, beat and rvalid are registered.
  - rvalid is high for exactly one cycle per beat.
  - The non-owner's rvalid stays 0.
  - Write bursts produce no rvalid.
- gnt is high in BURST and DONE for the owner only. At most one gnt is high at any time.
- A requester drops req in the cycle after done. IDLE therefore never re-grants a stale request.
- A req that drops mid-burst is ignored: the burst runs to completion and done still pulses.
- An address change mid-burst has no effect.
- Reset low on a clock edge forces the FSM to IDLE from any state, including mid-burst.
  - Reset values: all outputs 0, beat counter 0, last_owner=I.
  - Any in-flight memory beat is abandoned.

## Timing
- A req seen in IDLE at cycle t gives gnt and mem_en at t+1.
- With mem_ready tied to 1:
  - beats complete at t+1 .. t+BLOCK_WORDS;
  - the rvalid for beat k appears at t+2+k;
  - done coincides with the last rvalid, at t+BLOCK_WORDS+1;
  - IDLE is reached at t+BLOCK_WORDS+2.
- Each cycle of mem_ready=0 delays all later events by one cycle.
- There is one IDLE bubble between consecutive bursts. The earliest next grant is t+BLOCK_WORDS+3.
- d_widx → d_wdata → mem_wdata is a combinational path within a single cycle.

## Structure
- Package mips_mem_pkg holds:
  - the state enum (IDLE, BURST, DONE);
  - the owner enum (OWN_I, OWN_D);
  - the BLOCK_WORDS default;
  - the function computing the beat-field width.
- One sub-module, rr_arb2: a combinational two-way round-robin pick. Inputs: two requests and last_owner. Output: the winner.
- All sequencing stays in mem_arbiter.

## Test plan
- Reset, then I read with i_addr=0x104 and mem_ready=1.
  - Expect mem_addr 0x100, 0x104, 0x108, 0x10C on cycles 1..4.
  - Expect i_rvalid with beat 0..3 on cycles 2..5, and i_done on cycle 5.
- D write-back with d_addr=0x7C0 and d_wdata = 0xA0+d_widx.
  - Expect four writes with mem_we=1 and data 0xA0..0xA3 to 0x7C0..0x7CC.
  - Expect no d_rvalid and a single d_done pulse.
- i_req and d_req rise together after reset.
  - Expect the D side granted first (last_owner=I).
  - Then, with both still requesting, expect the I side granted next.
- D read with mem_ready low 2 cycles per beat.
  - Expect mem_addr held stable while mem_ready is low and exactly four d_rvalid pulses.
  - Expect d_done at grant+12.
- reset driven low during beat 2 of an I burst.
  - Expect all outputs 0 on the next edge.
  - After release, expect a fresh d_req to be granted at beat 0.
- i_req dropped after the first beat.
  - Expect the burst to complete all four beats, i_done to pulse, and no re-grant.
